controller_bus_arbiter: RTL and testbench
=========================================

# controller_bus_arbiter

Sequences ownership of the shared PHY SCL/SDA drivers between the four controller personalities: I2C active, I2C standby, I3C active and I3C standby. It sits between the per-controller open-drain outputs and the PHY. It grants the bus to exactly one controller, and it changes owner only at a clean bus boundary: drain the current owner, release the lines, wait for bus idle, then hand over.

## Interface
- NumCtrl, 4: number of controllers; index = mode encoding.
- HandoverCycles, 4: cycles with both lines released before a new owner is enabled; must be ≥1.
- DrainTimeout, 1024: cycles allowed for the owner to finish before forced release (only with the macro).
- clk_i  in  1  clock.
- rst_ni  in  1  reset; synchronous, active-low.
- phy_en_i  in  1  global PHY enable.
- mode_sel_i  in  2  requested owner (0 I2C active, 1 I2C standby, 2 I3C active, 3 I3C standby).
- mode_en_i  in  NumCtrl  per-controller config enable.
- bus_idle_i  in  1  bus-idle indication from the bus timers.
- stop_detect_i  in  1  single-cycle STOP pulse from the bus monitor.
- ctrl_scl_i  in  NumCtrl  per-controller SCL drive (1 = release).
- ctrl_sda_i  in  NumCtrl  per-controller SDA drive (1 = release).
- phy_scl_o  out  1  registered SCL to the PHY.
- phy_sda_o  out  1  registered SDA to the PHY.
- ctrl_enable_o  out  NumCtrl  one-hot (or zero) enable to the controllers.
- owner_o  out  2  current owner index; valid only with owner_valid_o.
- owner_valid_o  out  1  a controller owns the bus.
- switch_pending_o  out  1  high in DRAIN, RELEASE, WAIT_IDLE and HANDOVER.
- switch_done_o  out  1  one-cycle pulse on entry to OWNED.
- drain_timeout_o  out  1  one-cycle pulse on forced release.

## Operation
- States: DISABLED, WAIT_IDLE, HANDOVER, OWNED, DRAIN, RELEASE. The register `target` latches mode_sel_i.
- **DISABLED**
  - If phy_en_i && mode_en_i[mode_sel_i]: latch target, go to WAIT_IDLE.
- **WAIT_IDLE**
  - Lines released, enables 0.
  - If bus_idle_i: load counter = HandoverCycles-1, go to HANDOVER.
- **HANDOVER**
  - Lines released; counter decrements each cycle.
  - If bus_idle_i drops: return to WAIT_IDLE.
  - When counter==0: owner_o←target, ctrl_enable_o←onehot(target), go to OWNED, pulse switch_done_o.
- **OWNED**
  - phy lines are driven by ctrl_*_i[owner].
  - If mode_sel_i≠owner, or mode_en_i[owner]==0: go to DRAIN.
- **DRAIN**
  - Owner keeps driving and stays enabled.
  - If stop_detect_i or bus_idle_i: go to RELEASE.
  - If mode_sel_i returns to owner and mode_en_i[owner]==1: return to OWNED, with no switch_done_o pulse.
- **RELEASE** (one cycle)
  - Lines released, enables 0, owner_valid_o=0.
  - Next state: if mode_en_i[mode_sel_i], latch target and go to WAIT_IDLE; otherwise go to DISABLED.
- **Retarget:** if mode_sel_i changes in WAIT_IDLE or HANDOVER, re-latch target and go to WAIT_IDLE. If the new mode is disabled, go to DISABLED.
- **phy_en_i deasserted** (any state): go to DISABLED next cycle, with immediate release and no drain. This has priority over every other transition.
- Lines are wired-AND: released means 1. Outside OWNED and DRAIN, phy_scl_o = phy_sda_o = 1.
- Only one ctrl_enable_o bit is ever set. The enables are zero outside OWNED and DRAIN.

## Timing
- Reset values: phy_scl_o=1, phy_sda_o=1, ctrl_enable_o=0, owner_o=0, owner_valid_o=0, switch_pending_o=0, switch_done_o=0, drain_timeout_o=0; state = DISABLED.
- phy_*_o are registered, giving one cycle of latency from ctrl_*_i.
- Latency from request to ownership with bus_idle_i already high: DISABLED→WAIT_IDLE (1) →HANDOVER (1) →HandoverCycles cycles. owner_valid_o rises HandoverCycles+2 cycles after the request edge.
- The DRAIN exit condition is evaluated on the same cycle as stop_detect_i. RELEASE lasts exactly one cycle.
- Reset asserted mid-transfer: all outputs return to reset values on the next edge, with no drain.
- owner_valid_o=1 exactly in OWNED and DRAIN.

## Configuration
- Macro: CONTROLLER_BUS_ARBITER_DRAIN_TIMEOUT_EN.
- **Defined**
  - A counter of width $clog2(DrainTimeout+1) clears on entry to DRAIN and increments each DRAIN cycle.
  - At DrainTimeout it forces RELEASE and pulses drain_timeout_o.
- **Undefined**
  - DRAIN waits indefinitely for STOP or idle.
  - drain_timeout_o is tied to 0 and the counter is not instantiated.

## Structure
- controller_pkg gains typedef enum logic [1:0] ctrl_mode_e {CtrlI2cActive=0, CtrlI2cStandby=1, CtrlI3cActive=2, CtrlI3cStandby=3}.
- controller_pkg also gains the state enum bus_arb_state_e.
- No sub-module: the FSM, handover counter and output mux live in one module.

## Test plan
- **Basic grant:** reset, phy_en_i=1, mode_en_i=4'b1000, mode_sel_i=3, bus_idle_i=1.
  - owner_valid_o rises 6 cycles later, ctrl_enable_o=4'b1000, switch_done_o pulses once.
  - ctrl_sda_i[3]=0 gives phy_sda_o=0 one cycle later.
- **Switch with drain:** owner 3, change mode_sel_i to 2 with bus_idle_i=0.
  - Owner keeps driving and switch_pending_o=1.
  - stop_detect_i pulse leads to one RELEASE cycle with lines=1, then owner 2 after the idle wait plus 4 cycles.
- **Cancel:** in DRAIN, mode_sel_i returns to the owner.
  - Back to OWNED, no switch_done_o pulse, ctrl_enable_o unchanged.
- **Idle drop during HANDOVER:** bus_idle_i drops mid-countdown.
  - Back to WAIT_IDLE; full HandoverCycles restart after idle returns.
- **phy_en_i drop while OWNED:** lines=1 and enables=0 next cycle, state DISABLED.
  - A mid-DRAIN reset gives all outputs at reset values.
- **Timeout (macro on, DrainTimeout=16):** DRAIN with no STOP and no idle.
  - Forced RELEASE after 16 cycles, drain_timeout_o pulses once.
  - With the macro off, the bench stays in DRAIN.

Source files
------------

// File: rtl/controller_bus_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// controller_pkg
// Shared types for the controller bus arbiter:
//   ctrl_mode_e     - controller personality; the value is also the index into
//                     the per-controller enable and drive vectors.
//   bus_arb_state_e - ownership sequencing states of the arbiter.
//   is_bus_held()   - true in the states where a controller owns the lines.
// ----------------------------------------------------------------------------
package controller_pkg;

  typedef enum logic [1:0] {
    CtrlI2cActive  = 2'd0,
    CtrlI2cStandby = 2'd1,
    CtrlI3cActive  = 2'd2,
    CtrlI3cStandby = 2'd3
  } ctrl_mode_e;

  typedef enum logic [2:0] {
    ArbDisabled = 3'd0,
    ArbWaitIdle = 3'd1,
    ArbHandover = 3'd2,
    ArbOwned    = 3'd3,
    ArbDrain    = 3'd4,
    ArbRelease  = 3'd5
  } bus_arb_state_e;

  // The owner keeps its enable and keeps driving the lines while draining.
  function automatic logic is_bus_held(bus_arb_state_e s);
    return (s == ArbOwned) || (s == ArbDrain);
  endfunction

endpackage

// File: rtl/controller_bus_arbiter_if.sv
// ----------------------------------------------------------------------------
// controller_bus_arbiter_if
// Bundles the arbiter's request, bus-status, line-drive and status signals.
//   slave  modport : the arbiter side (takes *_i, drives *_o).
//   master modport : the surrounding controllers / PHY side.
// Signals:
//   phy_en_i         global PHY enable
//   mode_sel_i       requested owner index
//   mode_en_i        per-controller configuration enable
//   bus_idle_i       bus-idle indication from the bus timers
//   stop_detect_i    single-cycle STOP pulse from the bus monitor
//   ctrl_scl_i/sda_i per-controller open-drain drive (1 = release)
//   phy_scl_o/sda_o  registered lines to the PHY
//   ctrl_enable_o    one-hot (or zero) controller enable
//   owner_o          current owner, meaningful only with owner_valid_o
//   owner_valid_o    a controller owns the bus
//   switch_pending_o an ownership change is in progress
//   switch_done_o    one-cycle pulse when a new owner takes the bus
//   drain_timeout_o  one-cycle pulse when a drain is forcibly ended
// ----------------------------------------------------------------------------
interface controller_bus_arbiter_if #(
  parameter int NumCtrl = 4
);
  logic               phy_en_i;
  logic [1:0]         mode_sel_i;
  logic [NumCtrl-1:0] mode_en_i;
  logic               bus_idle_i;
  logic               stop_detect_i;
  logic [NumCtrl-1:0] ctrl_scl_i;
  logic [NumCtrl-1:0] ctrl_sda_i;
  logic               phy_scl_o;
  logic               phy_sda_o;
  logic [NumCtrl-1:0] ctrl_enable_o;
  logic [1:0]         owner_o;
  logic               owner_valid_o;
  logic               switch_pending_o;
  logic               switch_done_o;
  logic               drain_timeout_o;

  modport slave (
    input  phy_en_i, mode_sel_i, mode_en_i, bus_idle_i, stop_detect_i,
           ctrl_scl_i, ctrl_sda_i,
    output phy_scl_o, phy_sda_o, ctrl_enable_o, owner_o, owner_valid_o,
           switch_pending_o, switch_done_o, drain_timeout_o
  );

  modport master (
    output phy_en_i, mode_sel_i, mode_en_i, bus_idle_i, stop_detect_i,
           ctrl_scl_i, ctrl_sda_i,
    input  phy_scl_o, phy_sda_o, ctrl_enable_o, owner_o, owner_valid_o,
           switch_pending_o, switch_done_o, drain_timeout_o
  );
endinterface

// File: rtl/controller_bus_arbiter.sv
// ----------------------------------------------------------------------------
// controller_bus_arbiter
// Hands the shared PHY SCL/SDA drivers to exactly one of the four controller
// personalities (I2C active/standby, I3C active/standby). Ownership only moves
// at a clean bus boundary: drain the owner, release the lines for a cycle,
// wait for bus idle, hold the lines released for HandoverCycles, then enable
// the new owner.
// Ports:
//   clk_i   clock
//   rst_ni  synchronous, active-low reset
//   bus     controller_bus_arbiter_if.slave (requests, bus status, per-
//           controller drives in; PHY lines, enables and status out)
// Parameters:
//   NumCtrl        number of controllers (index = mode encoding)
//   HandoverCycles released-line cycles before a new owner is enabled (>= 1)
//   DrainTimeout   cycles allowed in DRAIN before a forced release
// Build option:
//   CONTROLLER_BUS_ARBITER_DRAIN_TIMEOUT_EN - when defined, a stuck DRAIN is
//   forcibly released after DrainTimeout cycles and drain_timeout_o pulses;
//   otherwise DRAIN waits for STOP or idle and drain_timeout_o is tied low.
// ----------------------------------------------------------------------------
module controller_bus_arbiter
  import controller_pkg::*;
#(
  parameter int NumCtrl        = 4,
  parameter int HandoverCycles = 4,
  parameter int DrainTimeout   = 1024
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  controller_bus_arbiter_if.slave  bus
);

  localparam int HoW = $clog2(HandoverCycles + 1);
  localparam logic [HoW-1:0] HoLoad = HoW'(HandoverCycles - 1);

  if (HandoverCycles < 1) begin : g_bad_handover
    $error("HandoverCycles must be at least 1");
  end
  if (DrainTimeout < 1) begin : g_bad_drain_timeout
    $error("DrainTimeout must be at least 1");
  end

  bus_arb_state_e state_q, state_d;
  ctrl_mode_e     target_q, target_d;
  ctrl_mode_e     owner_q, owner_d;
  ctrl_mode_e     sel_mode;
  logic [HoW-1:0] ho_cnt_q, ho_cnt_d;
  logic           phy_scl_q, phy_sda_q;
  logic           switch_done_q, switch_done_d;
  logic           sel_enabled;
  logic           owner_enabled;
  logic           timeout_hit;

  assign sel_mode      = ctrl_mode_e'(bus.mode_sel_i);
  assign sel_enabled   = bus.mode_en_i[bus.mode_sel_i];
  assign owner_enabled = bus.mode_en_i[owner_q];

`ifdef CONTROLLER_BUS_ARBITER_DRAIN_TIMEOUT_EN
  localparam int DtW = $clog2(DrainTimeout + 1);

  logic [DtW-1:0] drain_cnt_q;
  logic           drain_timeout_q;

  // Hitting the last allowed DRAIN cycle forces the release on the next edge.
  assign timeout_hit = (drain_cnt_q == DtW'(DrainTimeout - 1));

  // The counter is held at zero outside DRAIN, so every entry starts fresh.
  // The pulse is only raised when the timeout, not STOP/idle/cancel, ended DRAIN.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      drain_cnt_q     <= '0;
      drain_timeout_q <= 1'b0;
    end else begin
      if (state_q == ArbDrain) begin
        drain_cnt_q <= drain_cnt_q + 1'b1;
      end else begin
        drain_cnt_q <= '0;
      end
      drain_timeout_q <= (state_q == ArbDrain) && (state_d == ArbRelease) &&
                         !bus.stop_detect_i && !bus.bus_idle_i;
    end
  end

  assign bus.drain_timeout_o = drain_timeout_q;
`else
  assign timeout_hit         = 1'b0;
  assign bus.drain_timeout_o = 1'b0;
`endif

  // Dropping phy_en_i wins over everything: straight to DISABLED, no drain.
  // While a switch is still pre-ownership, a changed or disabled request
  // restarts the idle wait with the new target (or gives up if disabled).
  always_comb begin
    state_d       = state_q;
    target_d      = target_q;
    owner_d       = owner_q;
    ho_cnt_d      = ho_cnt_q;
    switch_done_d = 1'b0;

    if (!bus.phy_en_i) begin
      state_d = ArbDisabled;
    end else begin
      case (state_q)
        ArbDisabled: begin
          if (sel_enabled) begin
            target_d = sel_mode;
            state_d  = ArbWaitIdle;
          end
        end

        ArbWaitIdle: begin
          if ((sel_mode != target_q) || !sel_enabled) begin
            if (sel_enabled) begin
              target_d = sel_mode;
              state_d  = ArbWaitIdle;
            end else begin
              state_d = ArbDisabled;
            end
          end else if (bus.bus_idle_i) begin
            ho_cnt_d = HoLoad;
            state_d  = ArbHandover;
          end
        end

        ArbHandover: begin
          if ((sel_mode != target_q) || !sel_enabled) begin
            if (sel_enabled) begin
              target_d = sel_mode;
              state_d  = ArbWaitIdle;
            end else begin
              state_d = ArbDisabled;
            end
          end else if (!bus.bus_idle_i) begin
            state_d = ArbWaitIdle;
          end else if (ho_cnt_q == '0) begin
            owner_d       = target_q;
            state_d       = ArbOwned;
            switch_done_d = 1'b1;
          end else begin
            ho_cnt_d = ho_cnt_q - 1'b1;
          end
        end

        ArbOwned: begin
          if ((sel_mode != owner_q) || !owner_enabled) begin
            state_d = ArbDrain;
          end
        end

        // A STOP or idle bus is a safe boundary even if the request came back.
        ArbDrain: begin
          if (bus.stop_detect_i || bus.bus_idle_i) begin
            state_d = ArbRelease;
          end else if ((sel_mode == owner_q) && owner_enabled) begin
            state_d = ArbOwned;
          end else if (timeout_hit) begin
            state_d = ArbRelease;
          end
        end

        ArbRelease: begin
          if (sel_enabled) begin
            target_d = sel_mode;
            state_d  = ArbWaitIdle;
          end else begin
            state_d = ArbDisabled;
          end
        end

        default: state_d = ArbDisabled;
      endcase
    end
  end

  // PHY lines are computed from the next state so that they release in the
  // very cycle the arbiter leaves OWNED/DRAIN, yet follow the owner's drive
  // with one register of latency while it holds the bus.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= ArbDisabled;
      target_q      <= CtrlI2cActive;
      owner_q       <= CtrlI2cActive;
      ho_cnt_q      <= '0;
      phy_scl_q     <= 1'b1;
      phy_sda_q     <= 1'b1;
      switch_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      target_q      <= target_d;
      owner_q       <= owner_d;
      ho_cnt_q      <= ho_cnt_d;
      phy_scl_q     <= is_bus_held(state_d) ? bus.ctrl_scl_i[owner_d] : 1'b1;
      phy_sda_q     <= is_bus_held(state_d) ? bus.ctrl_sda_i[owner_d] : 1'b1;
      switch_done_q <= switch_done_d;
    end
  end

  assign bus.phy_scl_o        = phy_scl_q;
  assign bus.phy_sda_o        = phy_sda_q;
  assign bus.owner_o          = owner_q;
  assign bus.owner_valid_o    = is_bus_held(state_q);
  assign bus.ctrl_enable_o    = is_bus_held(state_q) ? (NumCtrl'(1) << owner_q) : '0;
  assign bus.switch_done_o    = switch_done_q;
  assign bus.switch_pending_o = (state_q == ArbWaitIdle) || (state_q == ArbHandover) ||
                                (state_q == ArbDrain)    || (state_q == ArbRelease);

endmodule

// File: tb/tb_controller_bus_arbiter.sv
// ----------------------------------------------------------------------------
// tb_controller_bus_arbiter
// Directed bench for controller_bus_arbiter (HandoverCycles=4, DrainTimeout=16).
// Inputs are driven on the falling edge, outputs are sampled on the falling
// edge after the rising edge under test. Expected values are hand-derived
// cycle counts from the ownership sequence.
// The timeout scenario follows CONTROLLER_BUS_ARBITER_DRAIN_TIMEOUT_EN.
// ----------------------------------------------------------------------------
module tb_controller_bus_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  controller_bus_arbiter_if #(.NumCtrl(4)) bus_if ();

  controller_bus_arbiter #(
    .NumCtrl(4),
    .HandoverCycles(4),
    .DrainTimeout(16)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus_if)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic check_reset_values(input string prefix);
    check_output({prefix, "_phy_scl"}, 32'(bus_if.phy_scl_o), 1);
    check_output({prefix, "_phy_sda"}, 32'(bus_if.phy_sda_o), 1);
    check_output({prefix, "_enable"}, 32'(bus_if.ctrl_enable_o), 0);
    check_output({prefix, "_owner"}, 32'(bus_if.owner_o), 0);
    check_output({prefix, "_valid"}, 32'(bus_if.owner_valid_o), 0);
    check_output({prefix, "_pending"}, 32'(bus_if.switch_pending_o), 0);
    check_output({prefix, "_done"}, 32'(bus_if.switch_done_o), 0);
    check_output({prefix, "_timeout"}, 32'(bus_if.drain_timeout_o), 0);
  endtask

  initial begin
    rst_n                = 1'b0;
    bus_if.phy_en_i      = 1'b0;
    bus_if.mode_sel_i    = 2'd0;
    bus_if.mode_en_i     = 4'b0000;
    bus_if.bus_idle_i    = 1'b0;
    bus_if.stop_detect_i = 1'b0;
    bus_if.ctrl_scl_i    = 4'b1111;
    bus_if.ctrl_sda_i    = 4'b1111;

    // Reset state
    tick(2);
    check_reset_values("reset");
    rst_n = 1'b1;
    tick(1);

    // Basic grant of controller 3 with the bus already idle
    $display("[TB] basic grant");
    bus_if.phy_en_i   = 1'b1;
    bus_if.mode_en_i  = 4'b1000;
    bus_if.mode_sel_i = 2'd3;
    bus_if.bus_idle_i = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick(1);
      check_output($sformatf("grant_valid_c%0d", i), 32'(bus_if.owner_valid_o), 0);
      check_output($sformatf("grant_pending_c%0d", i), 32'(bus_if.switch_pending_o), 1);
    end
    tick(1);
    check_output("grant_valid", 32'(bus_if.owner_valid_o), 1);
    check_output("grant_enable", 32'(bus_if.ctrl_enable_o), 32'h8);
    check_output("grant_owner", 32'(bus_if.owner_o), 3);
    check_output("grant_done", 32'(bus_if.switch_done_o), 1);
    check_output("grant_pending_low", 32'(bus_if.switch_pending_o), 0);
    bus_if.ctrl_sda_i = 4'b0111;
    bus_if.ctrl_scl_i = 4'b1101;
    tick(1);
    check_output("grant_done_once", 32'(bus_if.switch_done_o), 0);
    check_output("owner_sda_low", 32'(bus_if.phy_sda_o), 0);
    check_output("nonowner_scl_masked", 32'(bus_if.phy_scl_o), 1);

    // Switch 3 -> 2 on a busy bus, drained by a STOP
    $display("[TB] switch with drain");
    bus_if.mode_en_i  = 4'b1100;
    bus_if.bus_idle_i = 1'b0;
    bus_if.mode_sel_i = 2'd2;
    tick(1);
    check_output("drain_valid", 32'(bus_if.owner_valid_o), 1);
    check_output("drain_enable", 32'(bus_if.ctrl_enable_o), 32'h8);
    check_output("drain_pending", 32'(bus_if.switch_pending_o), 1);
    check_output("drain_sda_driven", 32'(bus_if.phy_sda_o), 0);
    tick(3);
    check_output("drain_hold_valid", 32'(bus_if.owner_valid_o), 1);
    check_output("drain_hold_sda", 32'(bus_if.phy_sda_o), 0);
    bus_if.stop_detect_i = 1'b1;
    tick(1);
    bus_if.stop_detect_i = 1'b0;
    check_output("release_valid", 32'(bus_if.owner_valid_o), 0);
    check_output("release_enable", 32'(bus_if.ctrl_enable_o), 0);
    check_output("release_pending", 32'(bus_if.switch_pending_o), 1);
    check_output("release_sda", 32'(bus_if.phy_sda_o), 1);
    check_output("release_scl", 32'(bus_if.phy_scl_o), 1);
    tick(1);
    check_output("waitidle_pending", 32'(bus_if.switch_pending_o), 1);
    tick(2);
    check_output("waitidle_valid", 32'(bus_if.owner_valid_o), 0);
    bus_if.bus_idle_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick(1);
      check_output($sformatf("switch_valid_c%0d", i), 32'(bus_if.owner_valid_o), 0);
    end
    tick(1);
    check_output("switch_valid", 32'(bus_if.owner_valid_o), 1);
    check_output("switch_owner", 32'(bus_if.owner_o), 2);
    check_output("switch_enable", 32'(bus_if.ctrl_enable_o), 32'h4);
    check_output("switch_done", 32'(bus_if.switch_done_o), 1);
    check_output("switch_sda_from_owner2", 32'(bus_if.phy_sda_o), 1);

    // Cancel: request returns to the owner while draining
    $display("[TB] cancel");
    bus_if.bus_idle_i = 1'b0;
    bus_if.mode_sel_i = 2'd3;
    tick(1);
    check_output("cancel_drain_pending", 32'(bus_if.switch_pending_o), 1);
    tick(1);
    check_output("cancel_drain_valid", 32'(bus_if.owner_valid_o), 1);
    bus_if.mode_sel_i = 2'd2;
    tick(1);
    check_output("cancel_pending", 32'(bus_if.switch_pending_o), 0);
    check_output("cancel_done", 32'(bus_if.switch_done_o), 0);
    check_output("cancel_enable", 32'(bus_if.ctrl_enable_o), 32'h4);
    tick(1);
    check_output("cancel_done_next", 32'(bus_if.switch_done_o), 0);
    check_output("cancel_owner", 32'(bus_if.owner_o), 2);

    // Idle drops mid-handover: the countdown restarts in full
    $display("[TB] idle drop during handover");
    bus_if.mode_sel_i = 2'd3;
    tick(1);
    bus_if.stop_detect_i = 1'b1;
    tick(1);
    bus_if.stop_detect_i = 1'b0;
    tick(1);
    bus_if.bus_idle_i = 1'b1;
    tick(1);
    check_output("ho_pending", 32'(bus_if.switch_pending_o), 1);
    tick(1);
    bus_if.bus_idle_i = 1'b0;
    tick(1);
    check_output("ho_drop_valid", 32'(bus_if.owner_valid_o), 0);
    check_output("ho_drop_pending", 32'(bus_if.switch_pending_o), 1);
    tick(1);
    bus_if.bus_idle_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick(1);
      check_output($sformatf("ho_restart_valid_c%0d", i), 32'(bus_if.owner_valid_o), 0);
    end
    tick(1);
    check_output("ho_restart_valid", 32'(bus_if.owner_valid_o), 1);
    check_output("ho_restart_owner", 32'(bus_if.owner_o), 3);
    check_output("ho_restart_enable", 32'(bus_if.ctrl_enable_o), 32'h8);

    // phy_en_i drop while owned: immediate release
    $display("[TB] phy enable drop");
    bus_if.ctrl_scl_i = 4'b0111;
    tick(1);
    check_output("owned_scl_low", 32'(bus_if.phy_scl_o), 0);
    bus_if.phy_en_i = 1'b0;
    tick(1);
    check_output("phyoff_scl", 32'(bus_if.phy_scl_o), 1);
    check_output("phyoff_sda", 32'(bus_if.phy_sda_o), 1);
    check_output("phyoff_enable", 32'(bus_if.ctrl_enable_o), 0);
    check_output("phyoff_valid", 32'(bus_if.owner_valid_o), 0);
    check_output("phyoff_pending", 32'(bus_if.switch_pending_o), 0);
    tick(1);
    check_output("phyoff_stays", 32'(bus_if.switch_pending_o), 0);
    bus_if.phy_en_i = 1'b1;
    tick(1);
    check_output("phyon_waitidle", 32'(bus_if.switch_pending_o), 1);

    // Reset in the middle of a drain
    $display("[TB] reset during drain");
    tick(5);
    check_output("regrant_valid", 32'(bus_if.owner_valid_o), 1);
    bus_if.bus_idle_i = 1'b0;
    bus_if.mode_sel_i = 2'd2;
    tick(1);
    check_output("rstdrain_pending", 32'(bus_if.switch_pending_o), 1);
    check_output("rstdrain_sda", 32'(bus_if.phy_sda_o), 0);
    rst_n = 1'b0;
    tick(1);
    check_reset_values("middrain_reset");

    // Drain with neither STOP nor idle
    $display("[TB] drain timeout");
    rst_n             = 1'b1;
    bus_if.bus_idle_i = 1'b1;
    tick(6);
    check_output("to_grant_valid", 32'(bus_if.owner_valid_o), 1);
    check_output("to_grant_owner", 32'(bus_if.owner_o), 2);
    bus_if.bus_idle_i = 1'b0;
    bus_if.mode_sel_i = 2'd3;
    for (int i = 1; i <= 16; i++) begin
      tick(1);
      check_output($sformatf("to_drain_valid_c%0d", i), 32'(bus_if.owner_valid_o), 1);
      check_output($sformatf("to_drain_pulse_c%0d", i), 32'(bus_if.drain_timeout_o), 0);
    end
    tick(1);
`ifdef CONTROLLER_BUS_ARBITER_DRAIN_TIMEOUT_EN
    check_output("to_release_valid", 32'(bus_if.owner_valid_o), 0);
    check_output("to_release_pulse", 32'(bus_if.drain_timeout_o), 1);
    check_output("to_release_sda", 32'(bus_if.phy_sda_o), 1);
    tick(1);
    check_output("to_pulse_once", 32'(bus_if.drain_timeout_o), 0);
    check_output("to_waitidle_pending", 32'(bus_if.switch_pending_o), 1);
`else
    check_output("nto_still_drain", 32'(bus_if.owner_valid_o), 1);
    check_output("nto_pulse_low", 32'(bus_if.drain_timeout_o), 0);
    tick(8);
    check_output("nto_still_drain_later", 32'(bus_if.owner_valid_o), 1);
    check_output("nto_pending", 32'(bus_if.switch_pending_o), 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
